// File: rtl/nn_pkg.sv
// Shared types, default sizing and helpers for the neuron driver slice.
package nn_pkg;

  localparam int unsigned NN_DW      = 16;
  localparam int unsigned NN_N_IN    = 4;
  localparam int unsigned NN_MAC_LAT = 3;

  typedef enum logic [2:0] {
    StLoadW,
    StIdle,
    StCollect,
    StRun,
    StDrain,
    StResult
  } nd_state_e;

  function automatic int unsigned clog2(input int unsigned val);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < val) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/nd_xbuf.sv
// Input-vector register file with a registered, RD_LAT-deep read pipeline.
module nd_xbuf
  import nn_pkg::*;
#(
  parameter int unsigned N_IN   = NN_N_IN,
  parameter int unsigned DW     = NN_DW,
  parameter int unsigned RD_LAT = 1,
  localparam int unsigned AW    = clog2(N_IN)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q  [N_IN];
  logic [DW-1:0] pipe_q [RD_LAT];

  // Buffer contents are don't-care after reset, so no reset on storage.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Reads outside the start window push zeros so nrn_x idles at 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= rd_en_i ? mem_q[rd_addr_i] : '0;
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign rd_data_o = pipe_q[RD_LAT-1];

endmodule

// File: rtl/neuron_driver.sv
// Host-side sequencer: loads neuron weights, buffers an input vector, replays it
// in a gap-free start window, then returns the sampled spike downstream.
module neuron_driver
  import nn_pkg::*;
#(
  parameter int unsigned N_IN    = NN_N_IN,
  parameter int unsigned DW      = NN_DW,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned MAC_LAT = NN_MAC_LAT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wgt_valid,
  output logic          wgt_ready,
  input  logic [DW-1:0] wgt_data,
  input  logic          x_valid,
  output logic          x_ready,
  input  logic [DW-1:0] x_data,
  output logic          nrn_strWgt,
  output logic [DW-1:0] nrn_w,
  output logic          nrn_start,
  output logic [DW-1:0] nrn_x,
  input  logic          nrn_y,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          res_spike,
  output logic          busy
);

  localparam int unsigned AW   = clog2(N_IN);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned DLEN = RD_LAT + MAC_LAT;
  localparam int unsigned DCW  = clog2(DLEN) + 1;

  nd_state_e      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic           strwgt_q;
  logic [DW-1:0]  w_q;
  logic           spike_q;

  logic wgt_rdy, x_rdy, buf_we, rd_en, wgt_fire;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    wgt_rdy = 1'b0;
    x_rdy   = 1'b0;
    buf_we  = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      StLoadW: begin
        wgt_rdy = 1'b1;
        if (wgt_valid) begin
          if (cnt_q == CW'(N_IN - 1)) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StIdle: begin
        // A pending weight reload takes priority over a new input vector.
        wgt_rdy = 1'b1;
        x_rdy   = ~wgt_valid;
        if (wgt_valid) begin
          state_d = StLoadW;
          cnt_d   = CW'(1);
        end else if (x_valid) begin
          buf_we  = 1'b1;
          state_d = StCollect;
          cnt_d   = CW'(1);
        end
      end
      StCollect: begin
        x_rdy = 1'b1;
        if (x_valid) begin
          buf_we = 1'b1;
          if (cnt_q == CW'(N_IN - 1)) begin
            state_d = StRun;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StRun: begin
        rd_en = 1'b1;
        if (cnt_q == CW'(N_IN - 1)) begin
          state_d = StDrain;
          cnt_d   = '0;
          dcnt_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        if (dcnt_q == DCW'(DLEN - 1)) begin
          state_d = StResult;
          dcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      StResult: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StLoadW;
    endcase
  end

  assign wgt_fire = wgt_valid & wgt_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StLoadW;
      cnt_q    <= '0;
      dcnt_q   <= '0;
      strwgt_q <= 1'b0;
      w_q      <= '0;
      spike_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dcnt_q   <= dcnt_d;
      strwgt_q <= wgt_fire;
      if (wgt_fire) w_q <= wgt_data;
      if (state_q == StDrain && dcnt_q == DCW'(DLEN - 1)) spike_q <= nrn_y;
    end
  end

  nd_xbuf #(
    .N_IN   (N_IN),
    .DW     (DW),
    .RD_LAT (RD_LAT)
  ) u_xbuf (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (buf_we),
    .wr_addr_i (cnt_q[AW-1:0]),
    .wr_data_i (x_data),
    .rd_en_i   (rd_en),
    .rd_addr_i (cnt_q[AW-1:0]),
    .rd_data_o (nrn_x)
  );

  // Combinational readies are masked so every output reads 0 while rst is held.
  assign wgt_ready  = wgt_rdy & ~rst;
  assign x_ready    = x_rdy & ~rst;
  assign nrn_strWgt = strwgt_q;
  assign nrn_w      = w_q;
  assign nrn_start  = (state_q == StRun);
  assign res_valid  = (state_q == StResult);
  assign res_spike  = spike_q;
  assign busy       = (state_q != StIdle) & ~rst;

endmodule

// File: tb/tb_neuron_driver.sv
// Directed bench for neuron_driver with a behavioural neuron (weight RAM + MAC).
module tb_neuron_driver;
  import nn_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        wgt_valid, x_valid, res_ready;
  logic [15:0] wgt_data, x_data;
  logic        wgt_ready, x_ready, nrn_strWgt, nrn_start, nrn_y;
  logic        res_valid, res_spike, busy;
  logic [15:0] nrn_w, nrn_x;

  always #5 clk = ~clk;

  neuron_driver dut (
    .clk        (clk),
    .rst        (rst),
    .wgt_valid  (wgt_valid),
    .wgt_ready  (wgt_ready),
    .wgt_data   (wgt_data),
    .x_valid    (x_valid),
    .x_ready    (x_ready),
    .x_data     (x_data),
    .nrn_strWgt (nrn_strWgt),
    .nrn_w      (nrn_w),
    .nrn_start  (nrn_start),
    .nrn_x      (nrn_x),
    .nrn_y      (nrn_y),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_spike  (res_spike),
    .busy       (busy)
  );

  // Neuron model: mod-4 write pointer, weight k meets x operand k one cycle
  // after start cycle k, y valid 3 cycles after the last operand (one cycle only).
  logic [15:0] wram [4];
  logic [15:0] xq [8];
  logic        spk_q [4];
  int wp = 0, rp = 0, acc = 0, cd = 0, mac_last = 0, sigma = 0;
  int strobe_cnt = 0, start_cnt = 0, xi = 0, x_bad = 0, xrdy_bad = 0;
  int win_len = 0, win_bad = 0, res_cnt = 0;
  logic start_d = 1'b0, spike_m = 1'b0;

  always @(posedge clk) begin
    start_d <= nrn_start;
    if (nrn_strWgt) begin
      wram[wp]   <= nrn_w;
      wp         <= (wp + 1) % 4;
      strobe_cnt <= strobe_cnt + 1;
    end
    if (nrn_start) start_cnt <= start_cnt + 1;
    if (start_d) begin
      acc       <= acc + int'(wram[rp]) * int'(nrn_x);
      rp        <= (rp + 1) % 4;
      xq[xi % 8] <= nrn_x;
      xi        <= xi + 1;
    end else begin
      acc <= 0;
      if (nrn_x !== 16'd0) x_bad <= x_bad + 1;
    end
    if (start_d && !nrn_start) begin
      mac_last <= acc + int'(wram[rp]) * int'(nrn_x);
      spike_m  <= (acc + int'(wram[rp]) * int'(nrn_x)) > sigma;
      cd       <= 3;
    end else if (cd > 0) begin
      cd <= cd - 1;
    end
    if (nrn_start) begin
      win_len <= win_len + 1;
    end else begin
      if (start_d && win_len != 4) win_bad <= win_bad + 1;
      win_len <= 0;
    end
    if (x_ready && (dut.state_q == StRun || dut.state_q == StDrain)) xrdy_bad <= xrdy_bad + 1;
    if (res_valid && res_ready) begin
      spk_q[res_cnt % 4] <= res_spike;
      res_cnt            <= res_cnt + 1;
    end
  end

  assign nrn_y = (cd == 1) && spike_m;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called just after a negedge; returns just after a later negedge.
  task automatic send_w(input logic [15:0] d, input int gap);
    int n;
    n = 0;
    wgt_valid = 1'b1;
    wgt_data  = d;
    #1;
    while (!wgt_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) chk("w_timeout", 32'(n), 0);
    @(posedge clk);
    #1;
    wgt_valid = 1'b0;
    @(negedge clk);
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_x(input logic [15:0] d);
    int n;
    n = 0;
    x_valid = 1'b1;
    x_data  = d;
    #1;
    while (!x_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) chk("x_timeout", 32'(n), 0);
    @(posedge clk);
    #1;
    x_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_res();
    int n;
    n = 0;
    while (!res_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("res_valid_seen", 32'(res_valid), 1);
  endtask

  int b_start, b_xi, b_res, held;

  initial begin
    rst = 1'b1;
    wgt_valid = 1'b0; x_valid = 1'b0; res_ready = 1'b0;
    wgt_data = '0; x_data = '0;
    @(negedge clk);
    chk("rst_ctrl", {25'd0, wgt_ready, x_ready, busy, res_valid, nrn_start, nrn_strWgt, res_spike}, 0);
    chk("rst_data", {nrn_w, nrn_x}, 0);
    chk("rst_state", 32'(dut.state_q), 32'(StLoadW));
    rst = 1'b0;
    @(negedge clk);

    // Weight load with gaps
    send_w(16'd1, 2);
    send_w(16'd2, 0);
    send_w(16'd3, 3);
    send_w(16'd4, 1);
    @(negedge clk);
    chk("wload_strobes", 32'(strobe_cnt), 4);
    for (int i = 0; i < 4; i++) chk("wload_wram", 32'(wram[i]), 32'(i + 1));
    chk("wload_state", 32'(dut.state_q), 32'(StIdle));
    chk("wload_busy", 32'(busy), 0);

    // Spike case: MAC = 5+12+21+32 = 70 > 60
    sigma = 60;
    b_start = start_cnt;
    b_xi = xi;
    send_x(16'd5); send_x(16'd6); send_x(16'd7); send_x(16'd8);
    wait_res();
    chk("spk_start_cycles", 32'(start_cnt - b_start), 4);
    chk("spk_x_seq", {xq[b_xi % 8][7:0], xq[(b_xi + 1) % 8][7:0],
                      xq[(b_xi + 2) % 8][7:0], xq[(b_xi + 3) % 8][7:0]}, 32'h05060708);
    chk("spk_mac", 32'(mac_last), 70);
    chk("spk_spike", 32'(res_spike), 1);
    chk("spk_x_idle_zero", 32'(x_bad), 0);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("spk_valid_clear", 32'(res_valid), 0);
    res_ready = 1'b0;
    @(negedge clk);

    // No-spike case: 70 > 70 is false; result held while res_ready is low
    sigma = 70;
    send_x(16'd5); send_x(16'd6); send_x(16'd7); send_x(16'd8);
    wait_res();
    held = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (res_valid) held++;
    end
    chk("nsp_held", 32'(held), 5);
    chk("nsp_spike", 32'(res_spike), 0);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("nsp_valid_clear", 32'(res_valid), 0);
    chk("nsp_busy_idle", 32'(busy), 0);
    res_ready = 1'b0;
    @(negedge clk);

    // Arbitration: weight wins over x in IDLE
    wgt_valid = 1'b1; wgt_data = 16'd9;
    x_valid = 1'b1; x_data = 16'd77;
    #1;
    chk("arb_x_ready", 32'(x_ready), 0);
    chk("arb_w_ready", 32'(wgt_ready), 1);
    @(posedge clk);
    #1;
    wgt_valid = 1'b0; x_valid = 1'b0;
    chk("arb_state", 32'(dut.state_q), 32'(StLoadW));
    chk("arb_wcnt", 32'(dut.cnt_q), 1);
    chk("arb_strobe", {15'd0, nrn_strWgt, nrn_w}, {15'd0, 1'b1, 16'd9});
    @(negedge clk);
    send_w(16'd2, 0); send_w(16'd3, 0); send_w(16'd4, 0);
    @(negedge clk);
    chk("arb_reload_state", 32'(dut.state_q), 32'(StIdle));
    chk("arb_wram0", 32'(wram[0]), 9);

    // Back-to-back: weights 9,2,3,4; ones -> 18, twos -> 36; threshold 20
    sigma = 20;
    res_ready = 1'b1;
    b_res = res_cnt;
    for (int i = 0; i < 8; i++) send_x((i < 4) ? 16'd1 : 16'd2);
    held = 0;
    while (res_cnt - b_res < 2 && held < 60) begin
      @(negedge clk);
      held++;
    end
    chk("b2b_results", 32'(res_cnt - b_res), 2);
    chk("b2b_spike0", 32'(spk_q[b_res % 4]), 0);
    chk("b2b_spike1", 32'(spk_q[(b_res + 1) % 4]), 1);
    chk("b2b_mac1", 32'(mac_last), 36);
    chk("b2b_x_ready_run", 32'(xrdy_bad), 0);
    chk("b2b_window_len", 32'(win_bad), 0);
    res_ready = 1'b0;

    // Reset in start-window cycle 2
    send_x(16'd1); send_x(16'd2); send_x(16'd3); send_x(16'd4);
    chk("mid_start_on", 32'(nrn_start), 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_start_drop", 32'(nrn_start), 0);
    chk("mid_res_valid", 32'(res_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_state", 32'(dut.state_q), 32'(StLoadW));
    chk("mid_wgt_ready", 32'(wgt_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
